xt_lb_uart_tx: RTL and testbench
================================

XT_LB_UART_TX -- requirements
Module: xt_lb_uart_tx

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 8'h10: local-bus address of register DATA; STATUS at BASE_ADDR+1, BAUD_DIV at BASE_ADDR+2.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8: TX FIFO entries; power of two, 2..32.
REQ-003 SHALL have parameter DEFAULT_DIV, default 16'd868: BAUD_DIV reset value, clocks per bit.
REQ-004 SHALL have port clk  input  1: single clock, all logic rising-edge.
REQ-005 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-006 SHALL have port xt_lb  input  lb_slave_t: local-bus slave request (ren, wen, 8-bit addr, write_width, 32-bit wdata).
REQ-007 SHALL have port rdata  output  32: read data, registered.
REQ-008 SHALL have port tx  output  1: UART serial line, idle high.
REQ-009 SHALL have port irq  output  1: level high while FIFO empty and FSM IDLE.

Function
REQ-010 SHALL decode accesses only via MatchWLB/MatchRLB on the three addresses; write_width SHALL be ignored.
REQ-011 SHALL, on DATA write, push wdata[7:0] into FIFO when not full; when full, SHALL drop the byte and set sticky overflow flag OVF.
REQ-012 SHALL, on DATA write in the same cycle the FSM pops from a full FIFO, accept the byte (no OVF).
REQ-013 SHALL present STATUS as: bit0 BUSY (FSM not IDLE), bit1 FULL, bit2 EMPTY, bit3 OVF, bits[9:4] COUNT, others 0.
REQ-014 SHALL clear OVF on a STATUS write with wdata[3]=1; other STATUS bits read-only.
REQ-015 SHALL make BAUD_DIV[15:0] read/write; a written value of 0 SHALL be stored as 1.
REQ-016 SHALL return register contents on rdata the cycle after a matching ren; DATA reads 0; rdata SHALL be 0 in every cycle not following a matching read.
REQ-017 SHALL implement FSM IDLE -> START -> DATA -> STOP -> IDLE.
REQ-018 SHALL leave IDLE when FIFO non-empty, popping one byte and latching BAUD_DIV for the whole frame; BAUD_DIV writes mid-frame affect the next frame only.
REQ-019 SHALL hold each bit for exactly the latched divider cycles: START tx=0, DATA 8 bits LSB first, STOP tx=1; frame = 10*div cycles.
REQ-020 SHALL go from STOP directly to START (no idle bit) when FIFO non-empty at STOP end.
REQ-021 SHALL drive tx registered; tx falls the cycle after the pop.
REQ-022 SHALL use a 16-bit baud counter and 3-bit bit index, no wrap beyond frame.

Reset
REQ-023 SHALL, on rst, set tx=1, rdata=0, FSM IDLE, FIFO empty, OVF=0, BAUD_DIV=DEFAULT_DIV, counters 0; irq=1 after reset.
REQ-024 SHALL, on rst mid-frame, abort the frame with tx high the next cycle and discard FIFO contents.

Structure
REQ-025 SHALL place register offsets (DATA 0, STATUS 1, BAUD_DIV 2), STATUS bit positions and the FSM state enum in shared package XT_UART_Pkg; lb_slave_t and match functions SHALL come from XT_LBUS_Pkg.
REQ-026 SHALL instantiate one sub-module xt_sync_fifo (parameterized width/depth, push/pop/full/empty/count, synchronous reset).

Verification
REQ-027 SHALL cover: BAUD_DIV=4, DATA write 0x55 -> tx low 4 cycles, bits 1,0,1,0,1,0,1,0 each 4 cycles, high 4 cycles, 40 cycles total, irq rises after.
REQ-028 SHALL cover: 9 back-to-back DATA writes with depth 8 and FSM busy -> first popped, 8 queued, no OVF; 10th write while full -> OVF=1, STATUS COUNT=8.
REQ-029 SHALL cover: STATUS write 0x8 after overflow -> OVF=0 on next STATUS read; read returns on rdata exactly one cycle after ren, 0 otherwise.
REQ-030 SHALL cover: BAUD_DIV write 0 -> reads 1; BAUD_DIV write 8 mid-frame at div 4 -> current frame stays 40 cycles, next frame 80 cycles.
REQ-031 SHALL cover: two queued bytes 0xA5,0x3C -> second START immediately follows first STOP, no extra idle bit.
REQ-032 SHALL cover: rst asserted during DATA bit 3 -> tx=1 next cycle, STATUS reads 0x4, BAUD_DIV reads DEFAULT_DIV.

Source files
------------

// File: rtl/xt_lbus_pkg.sv
// rtl/xt_lbus_pkg.sv - local-bus slave request type and address match helpers
package XT_LBUS_Pkg;

  typedef struct packed {
    logic        ren;
    logic        wen;
    logic [7:0]  addr;
    logic [1:0]  write_width;
    logic [31:0] wdata;
  } lb_slave_t;

  function automatic logic MatchWLB(input lb_slave_t lb, input logic [7:0] addr);
    return lb.wen && (lb.addr == addr);
  endfunction

  function automatic logic MatchRLB(input lb_slave_t lb, input logic [7:0] addr);
    return lb.ren && (lb.addr == addr);
  endfunction

endpackage

// File: rtl/xt_uart_pkg.sv
// rtl/xt_uart_pkg.sv - UART TX register map, STATUS layout and FSM states
package XT_UART_Pkg;

  localparam logic [7:0] OFF_DATA   = 8'd0;
  localparam logic [7:0] OFF_STATUS = 8'd1;
  localparam logic [7:0] OFF_BAUD   = 8'd2;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_EMPTY   = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 4;
  localparam int STAT_CNT_MSB = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/xt_sync_fifo.sv
// rtl/xt_sync_fifo.sv - single-clock FIFO; a push into a full FIFO succeeds only alongside a pop
module xt_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_data;
  end

endmodule

// File: rtl/xt_lb_uart_tx.sv
// rtl/xt_lb_uart_tx.sv - local-bus UART transmitter: DATA/STATUS/BAUD_DIV registers, TX FIFO, 8N1 serializer
module xt_lb_uart_tx
  import XT_LBUS_Pkg::*;
  import XT_UART_Pkg::*;
#(
  parameter logic [7:0]  BASE_ADDR   = 8'h10,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic        clk,
  input  logic        rst,
  input  lb_slave_t   xt_lb,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [7:0] A_DATA   = BASE_ADDR + OFF_DATA;
  localparam logic [7:0] A_STATUS = BASE_ADDR + OFF_STATUS;
  localparam logic [7:0] A_BAUD   = BASE_ADDR + OFF_BAUD;

  uart_state_e r_state, w_state_nxt;
  logic [15:0] r_baud_cnt, w_baud_cnt_nxt;
  logic [2:0]  r_bit_idx, w_bit_idx_nxt;
  logic [7:0]  r_shift, w_shift_nxt;
  logic [15:0] r_div_lat, w_div_lat_nxt;
  logic        r_tx, w_tx_nxt;
  logic [15:0] r_baud_div;
  logic        r_ovf;
  logic [31:0] r_rdata;

  logic          w_wr_data, w_wr_status, w_wr_baud;
  logic          w_rd_status, w_rd_baud;
  logic          w_pop, w_full, w_empty, w_bit_end;
  logic [7:0]    w_fifo_data;
  logic [CW-1:0] w_fifo_count;
  logic [31:0]   w_status;
  logic          w_unused;

  assign w_wr_data   = MatchWLB(xt_lb, A_DATA);
  assign w_wr_status = MatchWLB(xt_lb, A_STATUS);
  assign w_wr_baud   = MatchWLB(xt_lb, A_BAUD);
  assign w_rd_status = MatchRLB(xt_lb, A_STATUS);
  assign w_rd_baud   = MatchRLB(xt_lb, A_BAUD);
  assign w_unused    = ^{xt_lb.write_width, xt_lb.wdata[31:16]};

  xt_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_wr_data),
    .i_data  (xt_lb.wdata[7:0]),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_fifo_count)
  );

  always_comb begin
    w_status = '0;
    w_status[STAT_BUSY]  = (r_state != ST_IDLE);
    w_status[STAT_FULL]  = w_full;
    w_status[STAT_EMPTY] = w_empty;
    w_status[STAT_OVF]   = r_ovf;
    w_status[STAT_CNT_MSB:STAT_CNT_LSB] = 6'(w_fifo_count);
  end

  // A DATA write into a full FIFO is only lost if the FSM is not popping that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_baud_div <= DEFAULT_DIV;
      r_ovf      <= 1'b0;
      r_rdata    <= '0;
    end else begin
      if (w_wr_baud)
        r_baud_div <= (xt_lb.wdata[15:0] == 16'd0) ? 16'd1 : xt_lb.wdata[15:0];
      if (w_wr_data && w_full && !w_pop)
        r_ovf <= 1'b1;
      else if (w_wr_status && xt_lb.wdata[STAT_OVF])
        r_ovf <= 1'b0;
      if (w_rd_status)    r_rdata <= w_status;
      else if (w_rd_baud) r_rdata <= {16'd0, r_baud_div};
      else                r_rdata <= '0;
    end
  end

  assign w_bit_end = (r_baud_cnt == r_div_lat - 16'd1);

  always_comb begin
    w_state_nxt    = r_state;
    w_baud_cnt_nxt = r_baud_cnt;
    w_bit_idx_nxt  = r_bit_idx;
    w_shift_nxt    = r_shift;
    w_div_lat_nxt  = r_div_lat;
    w_tx_nxt       = r_tx;
    w_pop          = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_tx_nxt = 1'b1;
        if (!w_empty) begin
          w_pop          = 1'b1;
          w_shift_nxt    = w_fifo_data;
          w_div_lat_nxt  = r_baud_div;
          w_baud_cnt_nxt = '0;
          w_tx_nxt       = 1'b0;
          w_state_nxt    = ST_START;
        end
      end
      ST_START: begin
        if (w_bit_end) begin
          w_baud_cnt_nxt = '0;
          w_bit_idx_nxt  = '0;
          w_tx_nxt       = r_shift[0];
          w_state_nxt    = ST_DATA;
        end else begin
          w_baud_cnt_nxt = r_baud_cnt + 16'd1;
        end
      end
      ST_DATA: begin
        if (w_bit_end) begin
          w_baud_cnt_nxt = '0;
          if (r_bit_idx == 3'd7) begin
            w_tx_nxt    = 1'b1;
            w_state_nxt = ST_STOP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
            w_shift_nxt   = {1'b0, r_shift[7:1]};
            w_tx_nxt      = r_shift[1];
          end
        end else begin
          w_baud_cnt_nxt = r_baud_cnt + 16'd1;
        end
      end
      ST_STOP: begin
        if (w_bit_end) begin
          w_baud_cnt_nxt = '0;
          if (!w_empty) begin
            w_pop         = 1'b1;
            w_shift_nxt   = w_fifo_data;
            w_div_lat_nxt = r_baud_div;
            w_tx_nxt      = 1'b0;
            w_state_nxt   = ST_START;
          end else begin
            w_tx_nxt    = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_baud_cnt_nxt = r_baud_cnt + 16'd1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_div_lat  <= DEFAULT_DIV;
      r_tx       <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_baud_cnt <= w_baud_cnt_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_shift    <= w_shift_nxt;
      r_div_lat  <= w_div_lat_nxt;
      r_tx       <= w_tx_nxt;
    end
  end

  assign rdata = r_rdata;
  assign tx    = r_tx;
  assign irq   = w_empty && (r_state == ST_IDLE);

endmodule

// File: tb/tb_xt_lb_uart_tx.sv
// tb/tb_xt_lb_uart_tx.sv - scoreboard bench: expected bytes queued on DATA writes, checked by a line receiver
module tb_xt_lb_uart_tx;
  import XT_LBUS_Pkg::*;

  localparam logic [7:0] A_DATA = 8'h10;
  localparam logic [7:0] A_STAT = 8'h11;
  localparam logic [7:0] A_BAUD = 8'h12;

  typedef struct {
    logic [7:0] data;
    int         div;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  lb_slave_t   xt_lb;
  logic [31:0] rdata;
  logic        tx;
  logic        irq;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  xt_lb_uart_tx #(
    .BASE_ADDR   (8'h10),
    .FIFO_DEPTH  (8),
    .DEFAULT_DIV (16'd868)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .xt_lb (xt_lb),
    .rdata (rdata),
    .tx    (tx),
    .irq   (irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic lb_write(input logic [7:0] a, input logic [31:0] d);
    xt_lb.wen   = 1'b1;
    xt_lb.addr  = a;
    xt_lb.wdata = d;
    @(posedge clk); #1;
    xt_lb.wen   = 1'b0;
    xt_lb.wdata = '0;
  endtask

  task automatic lb_read(input logic [7:0] a, output logic [31:0] d);
    xt_lb.ren  = 1'b1;
    xt_lb.addr = a;
    @(posedge clk); #1;
    xt_lb.ren = 1'b0;
    d = rdata;
  endtask

  task automatic read_strict(input logic [7:0] a, output logic [31:0] d);
    check("rdata_before_read", rdata, 32'h0);
    lb_read(a, d);
    @(posedge clk); #1;
    check("rdata_after_read", rdata, 32'h0);
  endtask

  task automatic push_byte(input logic [7:0] b, input int div);
    exp_t e;
    e.data = b;
    e.div  = div;
    sb_q.push_back(e);
    lb_write(A_DATA, {24'd0, b});
  endtask

  // Line receiver: every cycle of a frame is compared against the ideal waveform.
  int         cyc = 0;
  logic       prev_tx = 1'b1;
  bit         in_frame = 1'b0;
  int         bit_no, bit_cyc, frame_err;
  int         frames_started = 0;
  int         frames_done = 0;
  int         last_end_cyc = -1;
  int         last_gap = -1;
  logic [7:0] rx_byte;
  exp_t       cur;

  always @(negedge clk) begin
    logic expb;
    cyc++;
    if (rst) begin
      in_frame = 1'b0;
      prev_tx  = 1'b1;
    end else begin
      if (!in_frame && prev_tx === 1'b1 && tx === 1'b0) begin
        frames_started++;
        if (sb_q.size() == 0) begin
          check("unexpected_frame", 32'd1, 32'd0);
          cur.data = 8'h00;
          cur.div  = 4;
        end else begin
          cur = sb_q.pop_front();
        end
        if (last_end_cyc >= 0) last_gap = cyc - last_end_cyc - 1;
        in_frame  = 1'b1;
        bit_no    = 0;
        bit_cyc   = 0;
        frame_err = 0;
        rx_byte   = '0;
      end
      if (in_frame) begin
        if (bit_no == 0)      expb = 1'b0;
        else if (bit_no == 9) expb = 1'b1;
        else                  expb = cur.data[bit_no-1];
        if (tx !== expb) frame_err++;
        if (bit_no >= 1 && bit_no <= 8 && bit_cyc == cur.div / 2) rx_byte[bit_no-1] = tx;
        bit_cyc++;
        if (bit_cyc == cur.div) begin
          bit_cyc = 0;
          bit_no++;
        end
        if (bit_no == 10) begin
          check("rx_byte", {24'd0, rx_byte}, {24'd0, cur.data});
          check("frame_waveform_errors", frame_err, 0);
          frames_done++;
          last_end_cyc = cyc;
          in_frame     = 1'b0;
        end
      end
      prev_tx = tx;
    end
  end

  task automatic wait_frames(input int target, input int bound);
    int n = 0;
    while (frames_done < target && n < bound) begin
      @(posedge clk); #1;
      n++;
    end
    if (frames_done < target) check("frame_timeout", frames_done, target);
  endtask

  initial begin
    logic [31:0] d;
    int          n;
    int          started_at_rst;
    xt_lb = '0;
    rst   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", tx, 1'b1);
    check("rst_rdata", rdata, 32'h0);
    check("rst_irq", irq, 1'b1);
    rst = 1'b0;

    lb_read(A_STAT, d);  check("rst_status", d, 32'h4);
    lb_read(A_BAUD, d);  check("rst_baud", d, 32'd868);
    lb_write(A_BAUD, 32'd0);
    lb_read(A_BAUD, d);  check("baud_zero_as_one", d, 32'd1);
    lb_write(A_BAUD, 32'd4);
    lb_read(A_BAUD, d);  check("baud_4", d, 32'd4);
    lb_read(A_DATA, d);  check("data_reads_zero", d, 32'h0);

    // Single 0x55 frame at div 4.
    push_byte(8'h55, 4);
    repeat (3) @(posedge clk);
    #1;
    check("irq_low_busy", irq, 1'b0);
    wait_frames(1, 100);
    @(posedge clk); #1;
    check("irq_after_frame", irq, 1'b1);

    // Fill: one popped, eight queued, then one dropped.
    for (int i = 0; i < 9; i++) push_byte(8'h30 + 8'(i), 4);
    lb_read(A_STAT, d);  check("status_full_no_ovf", d, 32'h83);
    lb_write(A_DATA, 32'hEE);
    lb_read(A_STAT, d);  check("status_ovf", d, 32'h8B);
    lb_write(A_STAT, 32'h8);
    read_strict(A_STAT, d);
    check("status_ovf_cleared", d, 32'h83);
    wait_frames(10, 9 * 40 + 60);

    // Back-to-back frames with no idle bit.
    repeat (3) @(posedge clk);
    #1;
    push_byte(8'hA5, 4);
    push_byte(8'h3C, 4);
    wait_frames(12, 150);
    check("b2b_gap_cycles", last_gap, 0);

    // Divider change mid-frame applies to the next frame only.
    repeat (3) @(posedge clk);
    #1;
    push_byte(8'h0F, 4);
    repeat (10) @(posedge clk);
    #1;
    lb_write(A_BAUD, 32'd8);
    lb_read(A_BAUD, d);  check("baud_8", d, 32'd8);
    push_byte(8'hF0, 8);
    wait_frames(14, 200);
    @(posedge clk); #1;
    check("irq_after_div_change", irq, 1'b1);

    // Reset during data bit 3, with a second byte still queued.
    push_byte(8'h96, 8);
    push_byte(8'h11, 8);
    n = 0;
    while (!(in_frame && bit_no == 4) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (!(in_frame && bit_no == 4)) check("reach_bit3_timeout", n, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_tx_high", tx, 1'b1);
    rst = 1'b0;
    sb_q.delete();
    started_at_rst = frames_started;
    lb_read(A_STAT, d);  check("rst_mid_status", d, 32'h4);
    lb_read(A_BAUD, d);  check("rst_mid_baud", d, 32'd868);
    repeat (40) @(posedge clk);
    #1;
    check("no_frame_after_rst", frames_started, started_at_rst);
    check("scoreboard_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
